// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR definitions for the core's CSR blocks.
// Holds the CSR operation and privilege encodings, the counter-related CSR
// addresses and HPM address bases, the hardware performance counter defaults,
// and the read-modify-write helper used by every CSR block.
package csr_pkg;

  // CSR operation encodings
  localparam logic [2:0] CSR_WRITE = 3'd1;
  localparam logic [2:0] CSR_SET   = 3'd2;
  localparam logic [2:0] CSR_CLEAR = 3'd3;
  localparam logic [2:0] CSR_READ  = 3'd5;

  // Privilege levels
  localparam logic [1:0] PRIV_LVL_U = 2'b00;
  localparam logic [1:0] PRIV_LVL_S = 2'b01;
  localparam logic [1:0] PRIV_LVL_M = 2'b11;

  // Counter CSR addresses
  localparam logic [11:0] CSR_MCYCLE           = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET         = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER_BASE = 12'hB03;
  localparam logic [11:0] CSR_MCOUNTEREN       = 12'h306;
  localparam logic [11:0] CSR_MCOUNTINHIBIT    = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT_BASE   = 12'h323;
  localparam logic [11:0] CSR_SCOUNTEREN       = 12'h106;
  localparam logic [11:0] CSR_CYCLE            = 12'hC00;
  localparam logic [11:0] CSR_TIME             = 12'hC01;
  localparam logic [11:0] CSR_INSTRET          = 12'hC02;
  localparam logic [11:0] CSR_HPMCOUNTER_BASE  = 12'hC03;

  // Mask that reduces an address to its 32-entry counter bank base
  localparam logic [11:0] CSR_BANK_MASK = 12'hFE0;

  // Hardware performance counter defaults
  localparam int HPM_DEFAULT_NUM       = 4;
  localparam int HPM_DEFAULT_CNT_WIDTH = 64;
  localparam int HPM_MAX_NUM           = 29;

  // True for operations that modify the addressed CSR
  function automatic logic csr_is_write(input logic [2:0] op);
    return (op == CSR_WRITE) || (op == CSR_SET) || (op == CSR_CLEAR);
  endfunction

  // New CSR value for a read-modify-write operation
  function automatic logic [63:0] csr_apply_op(input logic [2:0]  op,
                                               input logic [63:0] old_val,
                                               input logic [63:0] operand);
    logic [63:0] res;
    res = old_val;
    case (op)
      CSR_WRITE: res = operand;
      CSR_SET:   res = old_val | operand;
      CSR_CLEAR: res = old_val & ~operand;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/riscv_hpm_counters_counter_cell.sv
// riscv_counter_cell: one width-parametrised performance counter.
// A CSR write in the same cycle as an increment wins; the counter wraps
// silently at 2^CNT_WIDTH-1.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_event         count event for this cycle
//   i_inhibit       counting disabled (mcountinhibit bit)
//   i_we, i_wdata   CSR write strobe and value (already truncated)
//   o_cnt           current counter value
module riscv_counter_cell #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_event,
  input  logic                 i_inhibit,
  input  logic                 i_we,
  input  logic [CNT_WIDTH-1:0] i_wdata,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_we) begin
      cnt_d = i_wdata;
    end else if (i_event && !i_inhibit) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/riscv_hpm_counters.sv
// riscv_hpm_counters: machine/user counter CSRs (mcycle, minstret,
// mhpmcounter3.., their user-mode shadows) plus mcounteren, scounteren,
// mcountinhibit and mhpmevent selectors.
// Ports:
//   i_riscv_clk, i_riscv_rst_n  clock, asynchronous active-low reset
//   i_csr_valid/addr/op/wdata   CSR access in this cycle
//   i_priv                      current privilege level
//   i_instret                   one instruction retired this cycle
//   i_events                    per-cycle event pulses for the HPM counters
//   o_csr_hit                   address decoded by this block
//   o_csr_rdata                 read data (zero when illegal or no hit)
//   o_csr_illegal               access raises an illegal-instruction trap
module riscv_hpm_counters
  import csr_pkg::*;
#(
  parameter int NUM_HPM   = HPM_DEFAULT_NUM,
  parameter int CNT_WIDTH = HPM_DEFAULT_CNT_WIDTH,
  parameter int NUM_EVT   = 8
) (
  input  logic               i_riscv_clk,
  input  logic               i_riscv_rst_n,
  input  logic               i_csr_valid,
  input  logic [11:0]        i_csr_addr,
  input  logic [2:0]         i_csr_op,
  input  logic [63:0]        i_csr_wdata,
  input  logic [1:0]         i_priv,
  input  logic               i_instret,
  input  logic [NUM_EVT-1:0] i_events,
  output logic               o_csr_hit,
  output logic [63:0]        o_csr_rdata,
  output logic               o_csr_illegal
);

  // Array sizes must stay non-zero even when no HPM counters exist
  localparam int NH    = (NUM_HPM == 0) ? 1 : NUM_HPM;
  localparam int NCELL = 2 + NUM_HPM;
  localparam int EVW   = $clog2(NUM_EVT + 1);
  // Implemented counter bits: 0 (cycle), 2 (instret), 3..2+NUM_HPM
  localparam logic [31:0] CNT_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

  logic [31:0]          mcounteren_q, mcounteren_d;
  logic [31:0]          scounteren_q, scounteren_d;
  logic [31:0]          mcountinhibit_q, mcountinhibit_d;
  logic [EVW-1:0]       mhpmevent_q [NH];
  logic [EVW-1:0]       mhpmevent_d [NH];

  logic [CNT_WIDTH-1:0] cnt_val [NCELL];
  logic [NH-1:0]        hpm_evt;

  logic [4:0]  n;
  logic        is_mcnt, is_ucnt, is_mevt, is_minh, is_mcen, is_scen;
  logic        any_hit, illegal_c, csr_we;
  logic [63:0] rdata_raw, wval;

  // Address decode. 0xB01 has no machine counter and 0xC01 (time) lives
  // elsewhere, so both fall out of the counter banks.
  always_comb begin
    n       = i_csr_addr[4:0];
    is_mcnt = ((i_csr_addr & CSR_BANK_MASK) == CSR_MCYCLE) && (n != 5'd1);
    is_ucnt = ((i_csr_addr & CSR_BANK_MASK) == CSR_CYCLE) && (i_csr_addr != CSR_TIME);
    is_minh = (i_csr_addr == CSR_MCOUNTINHIBIT);
    is_mevt = ((i_csr_addr & CSR_BANK_MASK) == CSR_MCOUNTINHIBIT) && (n >= 5'd3);
    is_mcen = (i_csr_addr == CSR_MCOUNTEREN);
    is_scen = (i_csr_addr == CSR_SCOUNTEREN);
    any_hit = is_mcnt | is_ucnt | is_minh | is_mevt | is_mcen | is_scen;
  end

  // Privilege checks; user-range reads are gated by the enable bit of the
  // counter selected by the low address bits.
  always_comb begin
    illegal_c = 1'b0;
    if ((is_mcnt || is_minh || is_mevt || is_mcen) && (i_priv != PRIV_LVL_M)) begin
      illegal_c = 1'b1;
    end
    if (is_scen && (i_priv == PRIV_LVL_U)) begin
      illegal_c = 1'b1;
    end
    if (is_ucnt) begin
      if (i_csr_op != CSR_READ) begin
        illegal_c = 1'b1;
      end else if (i_priv == PRIV_LVL_S) begin
        illegal_c = !mcounteren_q[n];
      end else if (i_priv == PRIV_LVL_U) begin
        illegal_c = !(mcounteren_q[n] && scounteren_q[n]);
      end
    end
  end

  // Read mux; unimplemented counters and selectors read as zero
  always_comb begin
    rdata_raw = '0;
    if (is_mcnt || is_ucnt) begin
      if (n == 5'd0) begin
        rdata_raw[CNT_WIDTH-1:0] = cnt_val[0];
      end else if (n == 5'd2) begin
        rdata_raw[CNT_WIDTH-1:0] = cnt_val[1];
      end
      for (int k = 0; k < NUM_HPM; k++) begin
        if (n == 5'(3 + k)) begin
          rdata_raw[CNT_WIDTH-1:0] = cnt_val[2+k];
        end
      end
    end else if (is_mevt) begin
      for (int k = 0; k < NUM_HPM; k++) begin
        if (n == 5'(3 + k)) begin
          rdata_raw[EVW-1:0] = mhpmevent_q[k];
        end
      end
    end else if (is_minh) begin
      rdata_raw[31:0] = mcountinhibit_q;
    end else if (is_mcen) begin
      rdata_raw[31:0] = mcounteren_q;
    end else if (is_scen) begin
      rdata_raw[31:0] = scounteren_q;
    end
  end

  assign o_csr_hit     = i_csr_valid & any_hit;
  assign o_csr_illegal = i_csr_valid & any_hit & illegal_c;
  assign o_csr_rdata   = (i_csr_valid && any_hit && !illegal_c) ? rdata_raw : 64'd0;

  assign wval   = csr_apply_op(i_csr_op, rdata_raw, i_csr_wdata);
  assign csr_we = i_csr_valid & any_hit & ~illegal_c & csr_is_write(i_csr_op);

  // Control register next state; hardwired-zero bits are masked on write
  always_comb begin
    mcounteren_d    = mcounteren_q;
    scounteren_d    = scounteren_q;
    mcountinhibit_d = mcountinhibit_q;
    for (int k = 0; k < NH; k++) begin
      mhpmevent_d[k] = mhpmevent_q[k];
    end
    if (csr_we) begin
      if (is_mcen) mcounteren_d    = wval[31:0] & CNT_MASK;
      if (is_scen) scounteren_d    = wval[31:0] & CNT_MASK;
      if (is_minh) mcountinhibit_d = wval[31:0] & CNT_MASK;
      if (is_mevt) begin
        for (int k = 0; k < NUM_HPM; k++) begin
          if (n == 5'(3 + k)) begin
            mhpmevent_d[k] = wval[EVW-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge i_riscv_clk or negedge i_riscv_rst_n) begin
    if (!i_riscv_rst_n) begin
      mcounteren_q    <= '0;
      scounteren_q    <= '0;
      mcountinhibit_q <= '0;
      for (int k = 0; k < NH; k++) begin
        mhpmevent_q[k] <= '0;
      end
    end else begin
      mcounteren_q    <= mcounteren_d;
      scounteren_q    <= scounteren_d;
      mcountinhibit_q <= mcountinhibit_d;
      for (int k = 0; k < NH; k++) begin
        mhpmevent_q[k] <= mhpmevent_d[k];
      end
    end
  end

  // HPM event select: selector 1..NUM_EVT picks i_events[sel-1], others count nothing
  always_comb begin
    hpm_evt = '0;
    for (int k = 0; k < NH; k++) begin
      for (int e = 0; e < NUM_EVT; e++) begin
        if (mhpmevent_q[k] == EVW'(e + 1)) begin
          hpm_evt[k] = i_events[e];
        end
      end
    end
  end

  // Cell c maps to counter number 0 (cycle), 2 (instret) or c+1 (hpm)
  for (genvar c = 0; c < NCELL; c++) begin : g_cell
    localparam int CB = (c == 0) ? 0 : c + 1;
    logic evt;
    if (c == 0) begin : g_cyc
      assign evt = 1'b1;
    end else if (c == 1) begin : g_ret
      assign evt = i_instret;
    end else begin : g_hpm
      assign evt = hpm_evt[c-2];
    end

    riscv_counter_cell #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cell (
      .i_clk    (i_riscv_clk),
      .i_rst_n  (i_riscv_rst_n),
      .i_event  (evt),
      .i_inhibit(mcountinhibit_q[CB]),
      .i_we     (csr_we && is_mcnt && (n == 5'(CB))),
      .i_wdata  (wval[CNT_WIDTH-1:0]),
      .o_cnt    (cnt_val[c])
    );
  end

endmodule

// File: doc/riscv_hpm_counters.md
RISCV_HPM_COUNTERS -- requirements
Module: riscv_hpm_counters

Interface
REQ-001 SHALL have parameter NUM_HPM, default 4, number of mhpmcounter3..(3+NUM_HPM-1), legal 0..29.
REQ-002 SHALL have parameter CNT_WIDTH, default 64, implemented counter width, legal 32..64.
REQ-003 SHALL have parameter NUM_EVT, default 8, width of the event input bus.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 i_riscv_clk  in  1  core clock, all state on rising edge.
REQ-006 i_riscv_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_csr_valid  in  1  CSR access this cycle.
REQ-008 i_csr_addr  in  12  CSR address.
REQ-009 i_csr_op  in  3  CSR_WRITE/CSR_SET/CSR_CLEAR/CSR_READ encodings from csr_pkg.
REQ-010 i_csr_wdata  in  64  write/set/clear operand.
REQ-011 i_priv  in  2  current privilege (PRIV_LVL_U/S/M).
REQ-012 i_instret  in  1  one instruction retired this cycle.
REQ-013 i_events  in  NUM_EVT  per-cycle event pulses.
REQ-014 o_csr_hit  out  1  address belongs to this block.
REQ-015 o_csr_rdata  out  64  read data, zero-extended from CNT_WIDTH.
REQ-016 o_csr_illegal  out  1  access raises ILLEGAL_INSTRUCTION.

Function
REQ-017 Map: mcycle 0xB00, minstret 0xB02, mhpmcounter(3+k) 0xB03+k, mcounteren 0x306, mcountinhibit 0x320, mhpmevent(3+k) 0x323+k, scounteren 0x106, cycle 0xC00, instret 0xC02, hpmcounter(3+k) 0xC03+k.
REQ-018 Unimplemented k>=NUM_HPM addresses in the above ranges SHALL hit, read zero, ignore writes, no illegal (hardwired-zero counters).
REQ-019 0xC01 (time) SHALL not hit.
REQ-020 o_csr_hit/o_csr_rdata/o_csr_illegal SHALL be combinational from the current-cycle inputs and state (0-cycle read latency).
REQ-021 Writes SHALL take effect on the next rising edge; new value = wdata (WRITE), old|wdata (SET), old&~wdata (CLEAR); READ never writes.
REQ-022 Counter n SHALL increment by 1 per cycle when its event is active and mcountinhibit[n]=0; mcycle event = every cycle, minstret = i_instret, hpm k = i_events[mhpmevent(3+k)-1] when selector 1..NUM_EVT, else none.
REQ-023 CSR write to a counter in the same cycle as its increment SHALL win; counter holds written value, increment dropped.
REQ-024 Counter at 2^CNT_WIDTH-1 SHALL wrap to 0 on increment, no flag.
REQ-025 Write bits above CNT_WIDTH SHALL be discarded; mhpmevent stores clog2(NUM_EVT+1) bits, rest read zero.
REQ-026 mcountinhibit bit1 and mcounteren/scounteren bit1 SHALL be hardwired 0; bits above 2+NUM_HPM hardwired 0.
REQ-027 Machine-range (0xB/0x3) access with i_priv!=M SHALL be illegal; scounteren access with i_priv=U SHALL be illegal.
REQ-028 User-range read with i_priv=S SHALL be illegal if mcounteren[n]=0; with i_priv=U illegal if mcounteren[n]=0 or scounteren[n]=0.
REQ-029 Any non-READ op to 0xC00-0xC1F SHALL be illegal.
REQ-030 Illegal access SHALL not modify state; o_csr_rdata SHALL be 0 when illegal or no hit.
REQ-031 Outputs SHALL be don't-care-free zero when i_csr_valid=0 (hit=0, illegal=0, rdata=0).

Reset
REQ-032 On i_riscv_rst_n low, all counters, mhpmevent, mcountinhibit, mcounteren, scounteren SHALL clear to 0 asynchronously.
REQ-033 Reset asserted mid-count or mid-write SHALL discard the pending write; counting resumes first edge after deassertion.

Structure
REQ-034 Counter CSR addresses, HPM address bases and NUM_HPM/CNT_WIDTH defaults SHALL be added to csr_pkg; op and priv encodings reused from it.
REQ-035 One sub-module riscv_counter_cell (width-parametrised counter with inhibit, event, write-priority) SHALL be instantiated 2+NUM_HPM times via generate.

Verification
REQ-036 Reset, run 10 cycles, M read 0xB00 -> 10 (+/-0 per chosen sample edge), 0xB02 with no i_instret -> 0.
REQ-037 M write mcycle=0xFFFF_FFFF_FFFF_FFFE with CNT_WIDTH=64, two idle cycles -> reads 0xFFFF_FFFF_FFFF_FFFF then 0.
REQ-038 mhpmevent3=2, pulse i_events[1] 5 times, mcountinhibit=0x8 then 3 more pulses -> mhpmcounter3 reads 5.
REQ-039 mcounteren=0x1, scounteren=0: S read 0xC00 -> legal; U read 0xC00 -> illegal; S read 0xC02 -> illegal.
REQ-040 CSR_SET 0xB02 with 0x4 while i_instret=1, minstret=3 -> next cycle 7, not 8.
REQ-041 U-mode CSR_WRITE 0xC00 and S-mode read 0xB00 -> illegal, state unchanged; NUM_HPM=4 read 0xB10 in M -> hit, 0, legal.
